// File: rtl/seq_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : seq_scan_ctrl_if
//  Brief    : Host-side bus of the word scanner: pattern config, scan request,
//             handshake status, serial probe taps and match results.
//  Revision : 1.0
// ============================================================================
interface seq_scan_ctrl_if #(
    parameter int DATA_W  = 16,
    parameter int PAT_LEN = 4,
    parameter int CNT_W   = $clog2(DATA_W + 1)
);
    logic               cfg_we;
    logic [PAT_LEN-1:0] cfg_pattern;
    logic               start;
    logic [DATA_W-1:0]  data_in;
    logic               busy;
    logic               done;
    logic               din;
    logic               dout;
    logic [CNT_W-1:0]   match_cnt;
    logic [DATA_W-1:0]  match_map;

    modport master (
        output cfg_we, cfg_pattern, start, data_in,
        input  busy, done, din, dout, match_cnt, match_map
    );

    modport slave (
        input  cfg_we, cfg_pattern, start, data_in,
        output busy, done, din, dout, match_cnt, match_map
    );
endinterface
`default_nettype wire

// File: rtl/seq_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : seq_scan_ctrl
//  Brief    : Serializes a parallel word MSB-first through a non-overlapping
//             Mealy pattern matcher; counts and maps completed matches.
//  Revision : 1.0
// ============================================================================
module seq_scan_ctrl #(
    parameter int                 DATA_W  = 16,
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PAT_RST = 4'b1010,
    parameter int                 CNT_W   = $clog2(DATA_W + 1)
) (
    input  wire logic      clk,
    input  wire logic      reset,
    seq_scan_ctrl_if.slave bus
);
    localparam int FILL_W = $clog2(PAT_LEN);
    localparam int STEP_W = $clog2(DATA_W);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_SHIFT = 2'd1;
    localparam logic [1:0] c_ST_DONE  = 2'd2;

    localparam logic [FILL_W-1:0] c_FILL_MAX  = FILL_W'(PAT_LEN - 1);
    localparam logic [STEP_W-1:0] c_STEP_LAST = STEP_W'(DATA_W - 1);

    logic [1:0]         r_state;
    logic [PAT_LEN-1:0] r_pattern;
    logic [DATA_W-1:0]  r_shift;
    logic [PAT_LEN-2:0] r_window;
    logic [FILL_W-1:0]  r_fill;
    logic [STEP_W-1:0]  r_step;
    logic [CNT_W-1:0]   r_cnt;
    logic [DATA_W-1:0]  r_map;
    logic               r_busy;
    logic               r_done;

    logic               w_din;
    logic               w_dout;
    logic [PAT_LEN-1:0] w_cand;
    logic [STEP_W-1:0]  w_bitpos;

    // The shift register drains to zero during a scan, so gating by state
    // only matters for keeping din low in IDLE/DONE explicitly.
    assign w_din    = (r_state == c_ST_SHIFT) & r_shift[DATA_W-1];
    assign w_cand   = {r_window, w_din};
    assign w_dout   = (r_state == c_ST_SHIFT) && (r_fill >= c_FILL_MAX) && (w_cand == r_pattern);
    assign w_bitpos = c_STEP_LAST - r_step;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_ST_IDLE;
            r_pattern <= PAT_RST;
            r_shift   <= '0;
            r_window  <= '0;
            r_fill    <= '0;
            r_step    <= '0;
            r_cnt     <= '0;
            r_map     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (bus.cfg_we) begin
                        r_pattern <= bus.cfg_pattern;
                    end
                    if (bus.start) begin
                        r_shift  <= bus.data_in;
                        r_window <= '0;
                        r_fill   <= '0;
                        r_step   <= '0;
                        r_cnt    <= '0;
                        r_map    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= c_ST_SHIFT;
                    end
                end
                c_ST_SHIFT: begin
                    r_window <= w_cand[PAT_LEN-2:0];
                    r_shift  <= {r_shift[DATA_W-2:0], 1'b0};
                    // Clearing fill on a hit forces PAT_LEN fresh bits before the next hit.
                    if (w_dout) begin
                        r_fill          <= '0;
                        r_cnt           <= r_cnt + CNT_W'(1);
                        r_map[w_bitpos] <= 1'b1;
                    end else if (r_fill != c_FILL_MAX) begin
                        r_fill <= r_fill + FILL_W'(1);
                    end
                    if (r_step == c_STEP_LAST) begin
                        r_done  <= 1'b1;
                        r_state <= c_ST_DONE;
                    end else begin
                        r_step <= r_step + STEP_W'(1);
                    end
                end
                c_ST_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.din       = w_din;
    assign bus.dout      = w_dout;
    assign bus.match_cnt = r_cnt;
    assign bus.match_map = r_map;
endmodule
`default_nettype wire

// File: tb/tb_seq_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_scan_ctrl
//  Brief    : Scoreboard bench for seq_scan_ctrl; directed scans queue their
//             expected results, a negedge monitor checks each DONE.
//  Revision : 1.0
// ============================================================================
module tb_seq_scan_ctrl;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    seq_scan_ctrl_if #(.DATA_W(16), .PAT_LEN(4)) bus ();

    seq_scan_ctrl #(
        .DATA_W (16),
        .PAT_LEN(4),
        .PAT_RST(4'b1010)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        logic [15:0] word;
        logic [4:0]  cnt;
        logic [15:0] map;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    // Monitor: rebuilds din stream and dout positions per scan, checks on DONE.
    int          m_steps;
    logic [15:0] m_din;
    logic [15:0] m_dmap;
    exp_t        m_e;

    always @(negedge clk) begin
        if (reset || !bus.busy) begin
            m_steps = 0;
            m_din   = '0;
            m_dmap  = '0;
        end else if (!bus.done) begin
            if (bus.dout && m_steps < 16) m_dmap[15-m_steps] = 1'b1;
            m_din = {m_din[14:0], bus.din};
            m_steps++;
        end else if (exp_q.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
        end else begin
            m_e = exp_q.pop_front();
            chk("match_cnt", 32'(bus.match_cnt), 32'(m_e.cnt));
            chk("match_map", 32'(bus.match_map), 32'(m_e.map));
            chk("dout_steps", 32'(m_dmap), 32'(m_e.map));
            chk("din_stream", 32'(m_din), 32'(m_e.word));
            chk("shift_cycles", 32'(m_steps), 32'd16);
            chk("done_din_dout", {30'd0, bus.din, bus.dout}, 32'd0);
        end
    end

    task automatic wait_idle(input string name);
        int i;
        for (i = 0; i < 40 && bus.busy; i++) begin
            @(posedge clk); #1;
        end
        if (bus.busy) chk({name, "_timeout"}, 32'd1, 32'd0);
    endtask

    task automatic scan(input logic [15:0] word, input logic we, input logic [3:0] pat,
                        input logic [4:0] ecnt, input logic [15:0] emap);
        exp_q.push_back('{word: word, cnt: ecnt, map: emap});
        bus.start       = 1'b1;
        bus.data_in     = word;
        bus.cfg_we      = we;
        bus.cfg_pattern = pat;
        @(posedge clk); #1;
        bus.start  = 1'b0;
        bus.cfg_we = 1'b0;
        wait_idle("scan");
        @(posedge clk); #1;
    endtask

    initial begin
        reset           = 1'b1;
        bus.start       = 1'b0;
        bus.cfg_we      = 1'b0;
        bus.cfg_pattern = '0;
        bus.data_in     = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_din_dout", {30'd0, bus.din, bus.dout}, 32'd0);
        chk("rst_cnt", 32'(bus.match_cnt), 32'd0);
        chk("rst_map", 32'(bus.match_map), 32'd0);

        // Periodic match with the reset pattern.
        scan(16'hAAAA, 1'b0, 4'b0000, 5'd4, 16'h1111);

        // Pattern write in IDLE, then a non-overlap scan.
        bus.cfg_we = 1'b1; bus.cfg_pattern = 4'b1111;
        @(posedge clk); #1;
        bus.cfg_we = 1'b0;
        scan(16'hFF00, 1'b0, 4'b0000, 5'd2, 16'h1100);

        // Simultaneous start and pattern write; no matches.
        scan(16'h0000, 1'b1, 4'b1010, 5'd0, 16'h0000);

        // Ignored requests during SHIFT step 5 and during DONE.
        exp_q.push_back('{word: 16'h6666, cnt: 5'd4, map: 16'h1111});
        bus.start = 1'b1; bus.data_in = 16'h6666; bus.cfg_we = 1'b1; bus.cfg_pattern = 4'b0110;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.cfg_we = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        bus.start = 1'b1; bus.data_in = 16'hFFFF; bus.cfg_we = 1'b1; bus.cfg_pattern = 4'b1111;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.cfg_we = 1'b0;
        for (int i = 0; i < 40 && !bus.done; i++) begin
            @(posedge clk); #1;
        end
        chk("ign_done_seen", 32'(bus.done), 32'd1);
        bus.start = 1'b1; bus.data_in = 16'hFFFF;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("ign_busy_after_done", 32'(bus.busy), 32'd0);
        chk("ign_cnt_held", 32'(bus.match_cnt), 32'd4);
        chk("ign_map_held", 32'(bus.match_map), 32'h1111);
        @(posedge clk); #1;
        // Pattern must still be 0110.
        scan(16'h6666, 1'b0, 4'b0000, 5'd4, 16'h1111);

        // Reset at step 8 of an AAAA scan (pattern 0110 would give no hits afterwards).
        bus.start = 1'b1; bus.data_in = 16'hAAAA;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (8) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_done", 32'(bus.done), 32'd0);
        chk("mid_rst_din_dout", {30'd0, bus.din, bus.dout}, 32'd0);
        chk("mid_rst_cnt", 32'(bus.match_cnt), 32'd0);
        chk("mid_rst_map", 32'(bus.match_map), 32'd0);
        scan(16'hAAAA, 1'b0, 4'b0000, 5'd4, 16'h1111);

        repeat (3) @(posedge clk);
        chk("pending_expectations", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/seq_scan_ctrl.md
# seq_scan_ctrl

Sequencing controller for the Mealy non-overlapping pattern-detection datapath. It accepts a parallel word and a programmable bit pattern, then serializes the word MSB-first, one bit per clock, through a built-in non-overlapping Mealy matcher. It counts matches, records where each match completed, and reports completion with a start/busy/done handshake. It sits between a parallel host interface and the serial detector path, letting software scan whole words without driving `din` bit by bit.

## Interface
- `DATA_W`, 16, width of the scanned word (≥ PAT_LEN)
- `PAT_LEN`, 4, pattern length in bits (2..8)
- `PAT_RST`, 4'b1010, pattern value loaded at reset
- `CNT_W`, $clog2(DATA_W+1), match counter width
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high reset
- `cfg_we`  in  1  pattern write strobe, honoured only in IDLE
- `cfg_pattern`  in  PAT_LEN  new pattern; MSB is the first bit expected
- `start`  in  1  scan request, honoured only in IDLE
- `data_in`  in  DATA_W  word to scan, captured on the accepted start
- `busy`  out  1  high in SHIFT and DONE
- `done`  out  1  one-cycle pulse in DONE
- `din`  out  1  serial bit currently presented to the matcher
- `dout`  out  1  Mealy match flag for the current bit
- `match_cnt`  out  CNT_W  number of matches in the last scan
- `match_map`  out  DATA_W  bit i set if a match completed on `data_in[i]`

## Operation
- The FSM has three states: IDLE, SHIFT and DONE.
- **IDLE**
  - `cfg_we` loads `cfg_pattern` into the pattern register.
  - `start` latches `data_in` into the shift register, clears `match_cnt`, `match_map`, the window and the fill counter, zeroes the step counter, and moves to SHIFT.
  - If `start` and `cfg_we` are both high, the new pattern takes effect for this scan.
- **SHIFT**
  - Runs for exactly DATA_W cycles, at step k = 0..DATA_W-1.
  - `din` = shift register MSB, which is `data_in[DATA_W-1-k]`.
  - `dout` = (fill ≥ PAT_LEN-1) && ({window[PAT_LEN-2:0], din} == pattern). It is combinational from registered state, with no added latency.
  - Register update at each edge:
    - window ← {window[PAT_LEN-2:0], din}.
    - If `dout`: fill ← 0, `match_cnt`+1, and `match_map[DATA_W-1-k]` ← 1.
    - Otherwise fill ← min(fill+1, PAT_LEN-1).
    - The shift register shifts left by one.
  - Because fill clears on a match, a new match needs PAT_LEN fresh bits. This gives strict non-overlapping semantics.
  - After step DATA_W-1, the FSM goes to DONE.
- **DONE**
  - Asserts `done` for one cycle, then returns to IDLE.
  - `start` and `cfg_we` are ignored in this cycle.
- Outside SHIFT, `din` = 0 and `dout` = 0.
- `match_cnt` and `match_map` hold their values from DONE until the next accepted `start`.
- While `busy`, `start` and `cfg_we` are ignored and have no side effects.
- `match_cnt` never wraps, since its maximum is DATA_W/PAT_LEN.

## Timing
- **Reset**
  - State = IDLE; `busy`, `done`, `din`, `dout` = 0.
  - `match_cnt` = 0, `match_map` = 0.
  - Pattern = `PAT_RST`; window and fill = 0.
- **Reset mid-scan** aborts on the next edge: all outputs take their reset values and the partial results are discarded.
- **Latency**, with `start` sampled at edge 0:
  - SHIFT occupies cycles 1..DATA_W.
  - `done` is high in cycle DATA_W+1.
  - The next `start` is accepted at the edge ending cycle DATA_W+2 at the earliest.
- **Counter visibility**
  - Final `match_cnt` and `match_map` are valid in the DONE cycle.
  - During SHIFT they update one edge after the corresponding `dout` pulse.

## Test plan
- **Periodic match:** PAT_RST 1010, start with `data_in` 16'hAAAA → `dout` pulses at steps 3, 7, 11, 15; `match_cnt` = 4; `match_map` = 16'h1111; `done` in cycle 17.
- **Non-overlap check:** `cfg_we` with pattern 4'b1111, then scan 16'hFF00 → `match_cnt` = 2, `match_map` = 16'h1100. An overlapping detector would report 5, which is a failure.
- **No match:** pattern 1010, scan 16'h0000 → `match_cnt` = 0, `match_map` = 0; `done` still in cycle 17; `dout` never high.
- **Ignored requests:**
  - Scan 16'h6666 with pattern 0110 → 4 matches, `match_map` 16'h1111.
  - Assert `start` with 16'hFFFF and `cfg_we` with pattern 1111 during step 5, and `start` again in the DONE cycle.
  - Required: results unchanged, pattern still 0110, `busy` drops after DONE.
- **Reset mid-scan:** reset at step 8 of a 16'hAAAA scan → next cycle IDLE, all outputs 0, pattern = 1010; a subsequent 16'hAAAA scan yields 4 matches.
